// File: rtl/aes_result_serializer_pkg.sv
// Shared constants and helpers for the AES result serializer.
package aes_result_serializer_pkg;

   localparam int unsigned AES_BLK_W = 128;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } rd_state_e;

   function automatic bit legal_word_w(input int unsigned word_w);
      return (word_w == 8) || (word_w == 16) || (word_w == 32) ||
             (word_w == 64) || (word_w == 128);
   endfunction

   // Bit offset of word number idx inside a block, honouring the drain order.
   function automatic int unsigned word_lsb(input int unsigned idx,
                                            input int unsigned word_w,
                                            input bit          msw_first);
      int unsigned n;
      n = AES_BLK_W / word_w;
      return msw_first ? (n - 1 - idx) * word_w : idx * word_w;
   endfunction

endpackage

// File: rtl/aes_word_select.sv
// N:1 word mux over a 128-bit block; output forced to zero when not valid.
module aes_word_select
   import aes_result_serializer_pkg::*;
#(
   parameter int unsigned WORD_W    = 32,
   parameter bit          MSW_FIRST = 1'b1,
   parameter int unsigned CNT_W     = 2
) (
   input  logic [AES_BLK_W-1:0] blk_i,
   input  logic [CNT_W-1:0]     idx_i,
   input  logic                 valid_i,
   output logic [WORD_W-1:0]    word_o
);

   localparam int unsigned N = AES_BLK_W / WORD_W;

   always_comb begin
      word_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (valid_i && (idx_i == CNT_W'(i))) begin
            word_o = blk_i[word_lsb(i, WORD_W, MSW_FIRST) +: WORD_W];
         end
      end
   end

endmodule

// File: rtl/aes_result_serializer.sv
// Buffers unmasked AES result blocks and drains them as words over valid/ready,
// zeroizing each slot once drained and wiping everything on key destruction.
module aes_result_serializer
   import aes_result_serializer_pkg::*;
#(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned DEPTH     = 2,
   parameter bit          MSW_FIRST = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 srst_i,
   input  logic                 res_valid_i,
   input  logic [AES_BLK_W-1:0] res_data_i,
   input  logic                 destruct_i,
   output logic [WORD_W-1:0]    word_o,
   output logic                 word_valid_o,
   input  logic                 word_ready_i,
   output logic                 word_last_o,
   output logic                 full_o,
   output logic                 overflow_o
);

   localparam int unsigned N     = AES_BLK_W / WORD_W;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   if (!legal_word_w(WORD_W)) begin : g_bad_word_w
      $error("aes_result_serializer: WORD_W must divide 128 (8/16/32/64/128)");
   end
   if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("aes_result_serializer: DEPTH must be a power of two >= 1");
   end

   logic [AES_BLK_W-1:0] slot_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [OCC_W-1:0]     occ_q, occ_d;
   logic                 overflow_q;
   rd_state_e            state_q, state_d;

   logic word_valid, full, last_word, xfer, pop_last, push, drop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A last-word pop frees its slot in the same cycle, so a capture is still accepted.
   assign full      = (occ_q == OCC_W'(DEPTH));
   assign last_word = (cnt_q == CNT_W'(N - 1));
   assign xfer      = word_valid & word_ready_i;
   assign pop_last  = xfer & last_word;
   assign push      = res_valid_i & (~full | pop_last) & ~destruct_i;
   assign drop      = res_valid_i & full & ~pop_last & ~destruct_i;

   always_comb begin
      occ_d = occ_q;
      case ({push, pop_last})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Read-side FSM: state register
   always_ff @(posedge clk_i) begin
      if (srst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Read-side FSM: next state
   always_comb begin
      state_d = state_q;
      if (destruct_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (push) state_d = ST_DRAIN;
            ST_DRAIN: if (pop_last && (occ_q == OCC_W'(1)) && !push) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Read-side FSM: outputs
   always_comb begin
      word_valid = 1'b0;
      if (state_q == ST_DRAIN) word_valid = 1'b1;
   end

   // Slot array, pointers, word counter and sticky overflow
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         occ_q      <= '0;
         overflow_q <= 1'b0;
      end else if (destruct_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         occ_q    <= '0;
      end else begin
         // Zeroize before the capture so a same-slot write wins when full.
         if (pop_last) begin
            slot_q[rd_ptr_q] <= '0;
            rd_ptr_q         <= ptr_inc(rd_ptr_q);
         end
         if (push) begin
            slot_q[wr_ptr_q] <= res_data_i;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (xfer) cnt_q <= last_word ? '0 : cnt_q + CNT_W'(1);
         occ_q <= occ_d;
         if (drop) overflow_q <= 1'b1;
      end
   end

   aes_word_select #(
      .WORD_W    (WORD_W),
      .MSW_FIRST (MSW_FIRST),
      .CNT_W     (CNT_W)
   ) u_word_select (
      .blk_i   (slot_q[rd_ptr_q]),
      .idx_i   (cnt_q),
      .valid_i (word_valid),
      .word_o  (word_o)
   );

   assign word_valid_o = word_valid;
   assign word_last_o  = word_valid & last_word;
   assign full_o       = full;
   assign overflow_o   = overflow_q;

endmodule
